// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised inter-stage pipeline register with stall, flush and occupancy
//
// Purpose:
//   Carries a DATA_W-bit payload plus a valid bit through DEPTH back-to-back
//   slots. Follows the core's global stall vector. When the upstream stage
//   stops and the downstream stage runs, it inserts bubbles. DEPTH=1 behaves
//   as the classic ID/EX latch.
//
// Optional feature macro: PIPE_STAGE_PERF_EN
//   When defined, it builds 32-bit saturating bubble and hold counters.
//   When undefined, both counter outputs are tied to zero.
//
// Ports:
//   clk             in   clock, all state on posedge
//   rst             in   synchronous reset, active-high
//   stall           in   global stall vector (1 = stop)
//   flush           in   synchronous kill of all slots
//   in_valid        in   upstream slot valid
//   in_data         in   upstream payload
//   out_valid       out  valid of last slot
//   out_data        out  payload of last slot
//   occupancy       out  registered count of valid slots
//   perf_bubble_cnt out  bubbles inserted
//   perf_hold_cnt   out  cycles held

module pipe_stage_reg #(
  parameter int                DATA_W    = 64,
  parameter int                DEPTH     = 1,
  parameter int                STALL_W   = 6,
  parameter int                STAGE_IDX = 2,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  localparam int               OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [OCC_W-1:0]   occupancy,
  output logic [31:0]        perf_bubble_cnt,
  output logic [31:0]        perf_hold_cnt
);

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  logic              slot_valid [DEPTH];
  logic [DATA_W-1:0] slot_data  [DEPTH];

  logic up_stop;
  logic dn_stop;
  logic enter;
  logic leave;
  logic unused_stall_bits;

  assign up_stop = stall[STAGE_IDX];
  assign dn_stop = stall[STAGE_IDX+1];

  // Only two bits of the global vector matter here.
  assign unused_stall_bits = ^stall;

  // On an advancing edge, a valid may enter s[0] and the last slot always shifts out.
  assign enter = (up_stop == NO_STOP) && in_valid;
  assign leave = slot_valid[DEPTH-1];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_valid[i] <= 1'b0;
        slot_data[i]  <= NOP_VALUE;
      end
      occupancy <= '0;
    end else if (dn_stop == STOP) begin
      // Hold. This also covers the illegal vector where upstream runs and downstream stops.
    end else begin
      for (int i = DEPTH - 1; i >= 1; i--) begin
        slot_valid[i] <= slot_valid[i-1];
        slot_data[i]  <= slot_data[i-1];
      end
      // A bubble and an invalid input both leave the entry slot at NOP.
      slot_valid[0] <= enter;
      slot_data[0]  <= enter ? in_data : NOP_VALUE;
      occupancy     <= occupancy + OCC_W'(enter) - OCC_W'(leave);
    end
  end

  assign out_valid = slot_valid[DEPTH-1];
  assign out_data  = slot_data[DEPTH-1];

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] bubble_cnt;
  logic [31:0] hold_cnt;

  // Flush counts as neither a bubble nor a hold, and it leaves the counters intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
      hold_cnt   <= '0;
    end else if (!flush) begin
      if (dn_stop == STOP) begin
        if (hold_cnt != 32'hFFFF_FFFF) hold_cnt <= hold_cnt + 32'd1;
      end else if (up_stop == STOP) begin
        if (bubble_cnt != 32'hFFFF_FFFF) bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end

  assign perf_bubble_cnt = bubble_cnt;
  assign perf_hold_cnt   = hold_cnt;
`else
  assign perf_bubble_cnt = 32'h0;
  assign perf_hold_cnt   = 32'h0;
`endif

  // Downstream stopping while upstream runs means the global stall logic is broken.
  always @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(up_stop == NO_STOP && dn_stop == STOP))
        else $warning("pipe_stage_reg: illegal stall vector %b, holding", stall);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg at DEPTH 1 and 3

module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        in_valid;
  logic [63:0] in_data;

  logic        o1_valid, o3_valid;
  logic [63:0] o1_data, o3_data;
  logic [0:0]  o1_occ;
  logic [1:0]  o3_occ;
  logic [31:0] o1_bub, o1_hold, o3_bub, o3_hold;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(o1_valid), .out_data(o1_data), .occupancy(o1_occ),
    .perf_bubble_cnt(o1_bub), .perf_hold_cnt(o1_hold)
  );

  pipe_stage_reg #(.DEPTH(3)) dut3 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(o3_valid), .out_data(o3_data), .occupancy(o3_occ),
    .perf_bubble_cnt(o3_bub), .perf_hold_cnt(o3_hold)
  );

  // Reference model: each pipe is a queue of entries, newest at the front.
  typedef struct packed {
    logic        v;
    logic [63:0] d;
  } entry_t;

  entry_t m1[$];
  entry_t m3[$];
  longint exp_bub  = 0;
  longint exp_hold = 0;

  task automatic model_clear();
    entry_t e;
    e.v = 1'b0;
    e.d = 64'h0;
    m1 = {};
    m3 = {};
    m1.push_back(e);
    for (int i = 0; i < 3; i++) m3.push_back(e);
  endtask

  task automatic model_advance(entry_t e);
    m1.push_front(e);
    void'(m1.pop_back());
    m3.push_front(e);
    void'(m3.pop_back());
  endtask

  function automatic int count_valid(entry_t q[$]);
    int n = 0;
    foreach (q[i]) n += int'(q[i].v);
    return n;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [63:0] eb, eh;
`ifdef PIPE_STAGE_PERF_EN
    eb = (exp_bub  > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : 64'(exp_bub);
    eh = (exp_hold > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : 64'(exp_hold);
`else
    eb = 64'h0;
    eh = 64'h0;
`endif
    check("d1_valid", 64'(o1_valid), 64'(m1[0].v));
    check("d1_data",  o1_data, m1[0].d);
    check("d1_occ",   64'(o1_occ), 64'(count_valid(m1)));
    check("d1_bub",   64'(o1_bub), eb);
    check("d1_hold",  64'(o1_hold), eh);
    check("d3_valid", 64'(o3_valid), 64'(m3[2].v));
    check("d3_data",  o3_data, m3[2].d);
    check("d3_occ",   64'(o3_occ), 64'(count_valid(m3)));
    check("d3_bub",   64'(o3_bub), eb);
    check("d3_hold",  64'(o3_hold), eh);
  endtask

  // Drive one cycle of inputs, update the model for that edge, then check #1 after the edge.
  task automatic apply(logic r, logic f, logic [5:0] s, logic iv, logic [63:0] id);
    entry_t e;
    rst      = r;
    flush    = f;
    stall    = s;
    in_valid = iv;
    in_data  = id;
    @(posedge clk);
    if (r) begin
      model_clear();
      exp_bub  = 0;
      exp_hold = 0;
    end else if (f) begin
      model_clear();
    end else if (s[3]) begin
      exp_hold++;
    end else if (s[2]) begin
      e.v = 1'b0;
      e.d = 64'h0;
      model_advance(e);
      exp_bub++;
    end else begin
      e.v = iv;
      e.d = iv ? id : 64'h0;
      model_advance(e);
    end
    #1;
    compare_all();
  endtask

  initial begin
    logic [5:0]  s;
    logic [63:0] d;
    int          r;

    model_clear();
    rst = 1'b1; flush = 1'b0; stall = '0; in_valid = 1'b0; in_data = '0;

    // Reset state
    apply(1, 0, 6'b000000, 0, 64'h0);
    check("reset_out_valid", 64'(o3_valid), 64'h0);
    check("reset_occ", 64'(o3_occ), 64'h0);

    // DEPTH=1 pass-through
    apply(0, 0, 6'b000000, 1, 64'hA5);
    check("d1_pass_data", o1_data, 64'hA5);
    check("d1_pass_occ", 64'(o1_occ), 64'h1);

    // Bubble: upstream stopped, downstream running
    apply(0, 0, 6'b000111, 1, 64'hFF);
    check("d1_bubble_valid", 64'(o1_valid), 64'h0);
    check("d1_bubble_data", o1_data, 64'h0);

    // DEPTH=3 latency and hold
    apply(1, 0, 6'b000000, 0, 64'h0);
    apply(0, 0, 6'b000000, 1, 64'h1);
    apply(0, 0, 6'b000000, 1, 64'h2);
    apply(0, 0, 6'b000000, 1, 64'h3);
    check("d3_first_out", o3_data, 64'h1);
    check("d3_full_occ", 64'(o3_occ), 64'h3);
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 6'b001111, 1, 64'h99);
      check("d3_hold_data", o3_data, 64'h1);
    end
`ifdef PIPE_STAGE_PERF_EN
    check("d3_hold_cnt4", 64'(o3_hold), 64'h4);
`endif

    // Flush overrides a hold
    apply(0, 1, 6'b001111, 1, 64'h55);
    check("flush_occ", 64'(o3_occ), 64'h0);
    check("flush_valid", 64'(o3_valid), 64'h0);

    // Mid-stream reset with nonzero counters, then a single item
    apply(0, 0, 6'b000100, 1, 64'h8);
    apply(0, 0, 6'b000000, 1, 64'h9);
    apply(0, 0, 6'b001100, 1, 64'hA);
    apply(1, 0, 6'b000000, 1, 64'hB);
    check("rst_bub_zero", 64'(o3_bub), 64'h0);
    check("rst_hold_zero", 64'(o3_hold), 64'h0);
    apply(0, 0, 6'b000000, 1, 64'h7);
    apply(0, 0, 6'b000000, 0, 64'hDEAD);
    apply(0, 0, 6'b000000, 0, 64'hBEEF);
    check("d3_seven_out", o3_data, 64'h7);

    // Illegal vector: hold and lose nothing
    apply(0, 0, 6'b000000, 1, 64'h21);
    apply(0, 0, 6'b000000, 1, 64'h22);
    apply(0, 0, 6'b001000, 1, 64'h23);
    apply(0, 0, 6'b000000, 0, 64'h0);
    check("illegal_no_loss", o3_data, 64'h21);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      s = 6'($urandom);
      case ($urandom_range(0, 9))
        6, 7:    begin s[2] = 1'b1; s[3] = 1'b0; end
        8, 9:    begin s[2] = 1'b1; s[3] = 1'b1; end
        default: begin s[2] = 1'b0; s[3] = 1'b0; end
      endcase
      d = {$urandom, $urandom};
      apply(r < 2, (r >= 2) && (r < 7), s, 1'($urandom), d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
